vif_rx_fifo: RTL
================

// Module: vif_rx_fifo
// PURPOSE
// - Downstream consumer stage for my_if producers: sinks data/valid and drives ready (AccessOut role).
// - Buffers accepted bytes in a small show-ahead FIFO, re-presents them on a valid/ready output port.
// - Keeps an accepted-byte counter for debug.
// - Decouples the combinational producer from downstream backpressure.
// PARAMETERS
// - DATA_W   8   payload width; matches my_if.data.
// - DEPTH    4   FIFO entries; power of two, >= 2.
// - CNT_W    16  width of the accepted-byte counter.
// PORTS
// - clk        in   1       single clock; all state changes on posedge.
// - rst        in   1       synchronous, active-high reset.
// - in_data    in   DATA_W  my_if.data from the producer.
// - in_valid   in   1       my_if.valid from the producer.
// - in_ready   out  1       my_if.ready to the producer.
// - out_data   out  DATA_W  head-of-FIFO payload.
// - out_valid  out  1       head entry present.
// - out_ready  in   1       downstream accepts head this cycle.
// - level      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
// - accepted   out  CNT_W   count of input handshakes; saturates at all-ones.
// BEHAVIOUR
// - Clocking and reset:
//   - One clock domain.
//   - Reset is synchronous and active-high.
//   - Reset takes priority over every other event in that cycle.
// - Reset values: wr_ptr=0, rd_ptr=0, level=0, accepted=0, out_valid=0, in_ready=1.
//   - out_data after reset is don't-care; checkers ignore it while out_valid=0.
// - Push: occurs iff in_valid && in_ready.
//   - in_ready = (level != DEPTH). It depends only on registered state, never on in_valid or out_ready.
// - Pop: occurs iff out_valid && out_ready.
//   - out_valid = (level != 0).
//   - out_data = mem[rd_ptr], show-ahead; there is no read latency.
// - Latency: a byte pushed in cycle N appears on out_data/out_valid in cycle N+1 at the earliest.
//   - No combinational in->out bypass, even when the FIFO is empty.
// - Simultaneous push and pop (0 < level < DEPTH): both take effect; level is unchanged.
// - Full (level==DEPTH): in_ready=0, so no push. A pop that cycle frees a slot; in_ready=1 next cycle.
// - Empty (level==0): out_valid=0 and out_ready is ignored. A push makes level=1 next cycle.
// - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - level is tracked separately, so full and empty are unambiguous.
// - Ordering: strict FIFO; no entry is dropped or duplicated.
// - accepted:
//   - Increments by 1 on each push.
//   - Holds at 2^CNT_W-1 once reached; it never wraps.
// - Reset mid-operation: all entries are discarded and state returns to reset values on the next edge.
//   - Any handshake in the reset cycle is ignored, including for the accepted count.
// - X-handling: in_data is stored only on a push. Memory contents are never reset.
// STRUCTURE
// - vif_pkg (shared package) holds:
//   - localparam VIF_DATA_W = 8.
//   - typedef logic [VIF_DATA_W-1:0] vif_data_t.
//   - typedef enum {VIF_IDLE, VIF_BUSY} vif_state_t, for sibling stages.
// - One sub-module, vif_fifo_ctrl:
//   - Owns the pointers, level, full/empty and the push/pop enables.
//   - The top owns the storage array and the accepted counter.
// - Top-level wiring to my_if:
//   - in_data  <= vif.data
//   - in_valid <= vif.valid
//   - vif.ready <= in_ready
// TESTING
// - T1 reset: assert rst 2 cycles with in_valid=1.
//   -> level=0, out_valid=0, in_ready=1, accepted=0.
// - T2 fill: push 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=0.
//   -> level=4, in_ready=0 in cycle 5, accepted=4, out_data=0x11.
// - T3 full push+pop: at level=4 hold in_valid=1 with 0x55 and set out_ready=1 for one cycle.
//   -> 0x11 popped, 0x55 not pushed that cycle, level=3, in_ready=1 next cycle.
// - T4 streaming: in_valid=out_ready=1 for 20 cycles with an incrementing byte.
//   -> output matches input order, 1-cycle latency.
//   -> level constant at 1; pointers wrap 5 times.
// - T5 saturation: CNT_W=4, 20 pushes with out_ready=1.
//   -> accepted stops at 15.
// - T6 mid-op reset: level=3, assert rst while in_valid=out_ready=1.
//   -> next cycle level=0, out_valid=0, accepted=0; no output handshake counted.

Source files
------------

// File: rtl/vif_pkg.sv
// Shared definitions for the vif stages.
//   VIF_DATA_W  : payload width carried on my_if.data
//   vif_data_t  : payload type
//   vif_state_t : coarse activity state, used by sibling stages
package vif_pkg;

    localparam int unsigned VIF_DATA_W = 8;

    typedef logic [VIF_DATA_W-1:0] vif_data_t;

    typedef enum logic {
        VIF_IDLE,
        VIF_BUSY
    } vif_state_t;

endpackage

// File: rtl/vif_fifo_ctrl.sv
// Pointer/occupancy controller for the vif receive FIFO.
// The storage array lives in the parent; this block only decides when a push or pop
// takes effect and where it lands.
//   clk, rst         : clock, synchronous active-high reset
//   push_req         : producer offers a byte (my_if.valid)
//   pop_req          : consumer takes the head (out_ready)
//   push_en, pop_en  : qualified handshakes for this cycle
//   full, empty      : occupancy flags, derived from the registered level only
//   wr_ptr, rd_ptr   : storage indices, wrap modulo DEPTH
//   level            : occupancy 0..DEPTH
module vif_fifo_ctrl
    import vif_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             push_en,
    output logic             pop_en,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [LVL_W-1:0] level
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    // Flags come from registered state only, so ready never depends on valid.
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_en = push_req && !full;
    assign pop_en  = pop_req && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push_en, pop_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign level  = level_q;

endmodule

// File: rtl/vif_rx_fifo.sv
// Receive stage for my_if producers: sinks data/valid, drives ready, and re-presents the
// bytes on a show-ahead valid/ready port. Hookup: in_data <= vif.data,
// in_valid <= vif.valid, vif.ready <= in_ready.
//   clk, rst             : clock, synchronous active-high reset
//   in_data/valid/ready  : producer side
//   out_data/valid/ready : consumer side; out_data is the head entry, no read latency
//   level                : occupancy 0..DEPTH
//   accepted             : input handshake count, saturating at all-ones
module vif_rx_fifo
    import vif_pkg::*;
#(
    parameter  int unsigned DATA_W = VIF_DATA_W,
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned LVL_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  accepted
);

    logic             push_en, pop_en, full, empty;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    vif_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .push_req (in_valid),
        .pop_req  (out_ready),
        .push_en  (push_en),
        .pop_en   (pop_en),
        .full     (full),
        .empty    (empty),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .level    (level)
    );

    // Storage is not reset; only entries below level are ever observed.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr] <= in_data;
    end

    // Output reads the registered array only, so a byte can't bypass to the output
    // in the cycle it is pushed.
    assign out_data  = mem_q[rd_ptr];
    assign out_valid = !empty;
    assign in_ready  = !full;

    logic [CNT_W-1:0] accepted_q, accepted_d;

    always_comb begin
        accepted_d = accepted_q;
        if (push_en && (accepted_q != '1)) accepted_d = accepted_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) accepted_q <= '0;
        else     accepted_q <= accepted_d;
    end

    assign accepted = accepted_q;

endmodule
